led_blink_multi: RTL and testbench

Parametrised multi-channel LED driver. Each channel independently runs one of four runtime-selectable modes: off, on, blink (toggle), or PWM (duty-cycle dimming).
- Per-channel period and duty are loaded through a simple write port.
- A global sync input phase-aligns all channels.
- Sits between board top-level LED pins and status/debug logic, e.g. CPU heartbeat, bus activity, error indication.

---
 rtl/led_blink_multi.sv | 110 +++++++++++
 tb/tb_led_blink_multi.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: per-channel off / on / blink / PWM modes,
// runtime config write port, global phase-align sync.
//
// Ports:
//   i_Clk        system clock, single domain
//   i_Reset      synchronous active-high reset
//   i_Wr_En      config write strobe (one cycle)
//   i_Wr_Ch      target channel; index >= N_CH is ignored
//   i_Wr_Mode    0 off, 1 on, 2 blink, 3 PWM
//   i_Wr_Period  counter terminal value (wrap every period+1 clocks)
//   i_Wr_Duty    PWM on-count
//   i_Sync       one-cycle pulse, restarts every channel counter
//   o_LED        registered LED drive, bit k = channel k
//   o_Tick       one-cycle pulse per channel at counter wrap
module led_blink_multi #(
  parameter int N_CH           = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_MODE   = 2,
  parameter int DEFAULT_PERIOD = 1250000,
  parameter int DEFAULT_DUTY   = 0
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Wr_En,
  input  logic [3:0]       i_Wr_Ch,
  input  logic [1:0]       i_Wr_Mode,
  input  logic [CNT_W-1:0] i_Wr_Period,
  input  logic [CNT_W-1:0] i_Wr_Duty,
  input  logic             i_Sync,
  output logic [N_CH-1:0]  o_LED,
  output logic [N_CH-1:0]  o_Tick
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    mode_e            mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] cnt;
    logic             led;
    logic             tick;
    logic             wr_hit;
    logic             wrap;

    // Out-of-range channel indices never match any k.
    assign wr_hit = i_Wr_En && (i_Wr_Ch == 4'(k));
    assign wrap   = (cnt == period);

    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        mode   <= mode_e'(2'(DEFAULT_MODE));
        period <= CNT_W'(DEFAULT_PERIOD);
        duty   <= CNT_W'(DEFAULT_DUTY);
        cnt    <= '0;
        led    <= 1'b0;
        tick   <= 1'b0;
      end else if (wr_hit) begin
        // A write restarts the channel, so a
        // shorter period never sees cnt > period.
        mode   <= mode_e'(i_Wr_Mode);
        period <= i_Wr_Period;
        duty   <= i_Wr_Duty;
        cnt    <= '0;
        led    <= 1'b0;
        tick   <= 1'b0;
      end else if (i_Sync) begin
        cnt  <= '0;
        tick <= 1'b0;
        if (mode == MODE_BLINK || mode == MODE_PWM)
          led <= 1'b0;
      end else begin
        unique case (mode)
          MODE_OFF: begin
            led  <= 1'b0;
            cnt  <= '0;
            tick <= 1'b0;
          end
          MODE_ON: begin
            led  <= 1'b1;
            cnt  <= '0;
            tick <= 1'b0;
          end
          MODE_BLINK: begin
            cnt  <= wrap ? '0 : cnt + CNT_W'(1);
            tick <= wrap;
            if (wrap)
              led <= ~led;
          end
          MODE_PWM: begin
            // Compare uses the pre-edge count:
            // one clock of latency from cnt.
            cnt  <= wrap ? '0 : cnt + CNT_W'(1);
            tick <= wrap;
            led  <= (cnt < duty);
          end
        endcase
      end
    end

    assign o_LED[k]  = led;
    assign o_Tick[k] = tick;
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench for led_blink_multi (N_CH=4, CNT_W=8, period 3).
// Expected values are hand-derived cycle by cycle.
module tb_led_blink_multi;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_Wr_En;
  logic [3:0] i_Wr_Ch;
  logic [1:0] i_Wr_Mode;
  logic [7:0] i_Wr_Period;
  logic [7:0] i_Wr_Duty;
  logic       i_Sync;
  logic [3:0] o_LED;
  logic [3:0] o_Tick;

  int nvec = 0;
  int nmis = 0;

  led_blink_multi #(
    .N_CH(4),
    .CNT_W(8),
    .DEFAULT_MODE(2),
    .DEFAULT_PERIOD(3),
    .DEFAULT_DUTY(0)
  ) dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .i_Wr_En(i_Wr_En),
    .i_Wr_Ch(i_Wr_Ch),
    .i_Wr_Mode(i_Wr_Mode),
    .i_Wr_Period(i_Wr_Period),
    .i_Wr_Duty(i_Wr_Duty),
    .i_Sync(i_Sync),
    .o_LED(o_LED),
    .o_Tick(o_Tick)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] ch,
                    input logic [1:0] md,
                    input logic [7:0] per,
                    input logic [7:0] dty);
    i_Wr_En     = 1'b1;
    i_Wr_Ch     = ch;
    i_Wr_Mode   = md;
    i_Wr_Period = per;
    i_Wr_Duty   = dty;
    step();
    i_Wr_En = 1'b0;
  endtask

  task automatic sync_pulse();
    i_Sync = 1'b1;
    step();
    i_Sync = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    i_Reset     = 1'b1;
    i_Wr_En     = 1'b0;
    i_Wr_Ch     = '0;
    i_Wr_Mode   = '0;
    i_Wr_Period = '0;
    i_Wr_Duty   = '0;
    i_Sync      = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_led", o_LED, 4'b0000);
    chk("rst_tick", o_Tick, 4'b0000);
    i_Reset = 1'b0;

    // Default blink, period 3: 0 x4, 1 x4
    for (int n = 1; n <= 8; n++) begin
      step();
      e = (n >= 4 && n <= 7) ? 4'hF : 4'h0;
      chk("blink_led", o_LED, e);
      e = (n % 4 == 0) ? 4'hF : 4'h0;
      chk("blink_tick", o_Tick, e);
    end

    // ch1 PWM period 9 duty 3
    wr(4'd1, 2'd3, 8'd9, 8'd3);
    chk("pwm_w0", o_LED & 4'b0010, 4'b0000);
    for (int j = 1; j <= 12; j++) begin
      step();
      e = (((j - 1) % 10) < 3) ? 4'b0010 : 4'b0000;
      chk("pwm3_led", o_LED & 4'b0010, e);
      e = (j == 10) ? 4'b0010 : 4'b0000;
      chk("pwm3_tick", o_Tick & 4'b0010, e);
    end

    // duty 0 -> constant low
    wr(4'd1, 2'd3, 8'd9, 8'd0);
    for (int j = 1; j <= 11; j++) begin
      step();
      chk("pwm0_led", o_LED & 4'b0010, 4'b0000);
    end

    // duty 10 > period -> constant high
    wr(4'd1, 2'd3, 8'd9, 8'd10);
    chk("pwm10_w0", o_LED & 4'b0010, 4'b0000);
    for (int j = 1; j <= 11; j++) begin
      step();
      chk("pwm10_led", o_LED & 4'b0010, 4'b0010);
    end

    // ch2 on, sync keeps level, then off
    wr(4'd2, 2'd1, 8'd3, 8'd0);
    chk("on_w0", o_LED & 4'b0100, 4'b0000);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("on_led", o_LED & 4'b0100, 4'b0100);
      chk("on_tick", o_Tick & 4'b0100, 4'b0000);
    end
    sync_pulse();
    chk("on_sync", o_LED & 4'b0100, 4'b0100);
    step();
    chk("on_sync1", o_LED & 4'b0100, 4'b0100);
    wr(4'd2, 2'd0, 8'd3, 8'd0);
    for (int j = 0; j <= 2; j++) begin
      chk("off_led", o_LED & 4'b0100, 4'b0000);
      chk("off_tick", o_Tick & 4'b0100, 4'b0000);
      step();
    end

    // ch0 period 4, ch3 period 6, sync mid-count,
    // with an out-of-range write (ch 7) along the way
    wr(4'd0, 2'd2, 8'd4, 8'd0);
    wr(4'd3, 2'd2, 8'd6, 8'd0);
    step();
    step();
    step();
    sync_pulse();
    chk("sync_led", o_LED, 4'b0000);
    chk("sync_tick", o_Tick, 4'b0000);
    for (int j = 1; j <= 8; j++) begin
      if (j == 3) begin
        wr(4'd7, 2'd1, 8'd0, 8'd0);
      end else begin
        step();
      end
      e = {j >= 7, 1'b0, 1'b1, j >= 5};
      chk("sync_run_led", o_LED, e);
      e = {j == 7, 1'b0, 1'b0, j == 5};
      chk("sync_run_tick", o_Tick, e);
    end

    // Write to ch2 concurrent with sync
    i_Sync = 1'b1;
    wr(4'd2, 2'd2, 8'd1, 8'd0);
    i_Sync = 1'b0;
    chk("cw_led0", o_LED & 4'b0101, 4'b0000);
    for (int j = 1; j <= 4; j++) begin
      step();
      e = (j == 2 || j == 3) ? 4'b0100 : 4'b0000;
      chk("cw_led", o_LED & 4'b0101, e);
      e = (j == 2 || j == 4) ? 4'b0100 : 4'b0000;
      chk("cw_tick", o_Tick & 4'b0101, e);
    end

    // Reset mid-PWM with a write and sync pending
    i_Reset = 1'b1;
    i_Sync  = 1'b1;
    wr(4'd1, 2'd1, 8'd0, 8'd0);
    i_Reset = 1'b0;
    i_Sync  = 1'b0;
    chk("rst2_led", o_LED, 4'b0000);
    chk("rst2_tick", o_Tick, 4'b0000);
    for (int j = 1; j <= 5; j++) begin
      step();
      e = (j >= 4) ? 4'hF : 4'h0;
      chk("rst2_run_led", o_LED, e);
      e = (j == 4) ? 4'hF : 4'h0;
      chk("rst2_run_tick", o_Tick, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
